// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer for the Hack CPU: loads a length-prefixed program stream into
// instruction ROM, holds the CPU in reset, releases it, and freezes it on a pc self-loop.
module cpu_boot_sequencer #(
    parameter int ADDR_W     = 15,
    parameter int MAX_WORDS  = 32768,
    parameter int RST_CYCLES = 4,
    parameter int HALT_COUNT = 3,
    parameter int TIMEOUT    = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              cpu_reset,
    output logic              cpu_clk_en,
    input  logic [15:0]       pc,
    output logic              halted,
    output logic              error,
    output logic [15:0]       word_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int HC_W = $clog2(HALT_COUNT + 1);
    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_RST,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [7:0]        data_hi_q, data_hi_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [HC_W-1:0]   stable_q, stable_d;
    logic [15:0]       prev_pc_q, prev_pc_d;

    logic              rx_ready_q, rx_ready_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       rom_data_q, rom_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              cpu_clk_en_q, cpu_clk_en_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic [15:0]       word_count_q, word_count_d;

    logic              accept;
    logic              loading;
    logic [15:0]       len_word;
    logic              len_bad;
    logic              last_word;
    logic              timeout_hit;

    assign accept      = rx_valid && rx_ready_q;
    assign loading     = (state_q == S_LEN_LO) || (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
    assign len_word    = {len_hi_q, rx_data};
    assign len_bad     = (len_word == 16'd0) || (32'(len_word) > MAX_WORDS_U);
    assign last_word   = (32'(idx_q) + 32'd1) == 32'(word_count_q);
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Next-state, counters and ROM write port.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        data_hi_d    = data_hi_q;
        idx_d        = idx_q;
        word_count_d = word_count_q;
        to_cnt_d     = '0;
        rst_cnt_d    = '0;
        stable_d     = '0;
        prev_pc_d    = pc;
        rom_we_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        rom_data_d   = rom_data_q;

        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_bad) begin
                        state_d = S_ERROR;
                    end else begin
                        word_count_d = len_word;
                        idx_d        = '0;
                        state_d      = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    data_hi_d = rx_data;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    rom_we_d   = 1'b1;
                    rom_addr_d = idx_q;
                    rom_data_d = {data_hi_q, rx_data};
                    idx_d      = idx_q + ADDR_W'(1);
                    state_d    = last_word ? S_RST : S_DATA_HI;
                end
            end
            S_RST: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            S_RUN: begin
                if (pc == prev_pc_q) begin
                    if (stable_q == HC_W'(HALT_COUNT - 1)) begin
                        state_d = S_HALTED;
                    end else begin
                        stable_d = stable_q + HC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accept in the same cycle as expiry keeps the transfer alive.
        if (loading && !accept) begin
            if (timeout_hit) begin
                state_d = S_ERROR;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // Registered status outputs follow the state being entered.
    always_comb begin
        rx_ready_d   = 1'b1;
        cpu_reset_d  = 1'b1;
        cpu_clk_en_d = 1'b0;
        halted_d     = 1'b0;
        error_d      = 1'b0;
        case (state_d)
            S_RST: begin
                rx_ready_d = 1'b0;
            end
            S_RUN: begin
                rx_ready_d   = 1'b0;
                cpu_reset_d  = 1'b0;
                cpu_clk_en_d = 1'b1;
            end
            S_HALTED: begin
                cpu_reset_d = 1'b0;
                halted_d    = 1'b1;
            end
            S_ERROR: begin
                error_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            data_hi_q    <= '0;
            idx_q        <= '0;
            to_cnt_q     <= '0;
            rst_cnt_q    <= '0;
            stable_q     <= '0;
            prev_pc_q    <= '0;
            rx_ready_q   <= 1'b1;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_clk_en_q <= 1'b0;
            halted_q     <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            data_hi_q    <= data_hi_d;
            idx_q        <= idx_d;
            to_cnt_q     <= to_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            stable_q     <= stable_d;
            prev_pc_q    <= prev_pc_d;
            rx_ready_q   <= rx_ready_d;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            halted_q     <= halted_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign cpu_reset  = cpu_reset_q;
    assign cpu_clk_en = cpu_clk_en_q;
    assign halted     = halted_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed bench for cpu_boot_sequencer: load, length errors, timeout, halt detect,
// reload from HALTED and reset mid-operation.
module tb_cpu_boot_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        cpu_reset;
    logic        cpu_clk_en;
    logic [15:0] pc;
    logic        halted;
    logic        error;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] wr_addr_log [$];
    logic [15:0] wr_data_log [$];

    localparam logic [52:0] RESET_VEC = {1'b1, 1'b0, 15'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};

    cpu_boot_sequencer #(
        .ADDR_W    (15),
        .MAX_WORDS (32768),
        .RST_CYCLES(4),
        .HALT_COUNT(3),
        .TIMEOUT   (50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cpu_reset (cpu_reset),
        .cpu_clk_en(cpu_clk_en),
        .pc        (pc),
        .halted    (halted),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            wr_addr_log.push_back(rom_addr);
            wr_data_log.push_back(rom_data);
        end
    end

    function automatic logic [52:0] out_vec();
        return {rx_ready, rom_we, rom_addr, rom_data, cpu_reset, cpu_clk_en, halted, error, word_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        pc = 16'hFFFF;
        tick();
        tick();
        n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL reset_hold: got %h want %h", out_vec(), RESET_VEC); end
        reset = 1'b0;
        tick();
        n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL reset_idle: got %h want %h", out_vec(), RESET_VEC); end
    endtask

    task automatic test_load_basic();
        int base;
        base = wr_addr_log.size();
        pc = 16'hFFFF;
        send_byte(8'h00);
        send_byte(8'h02);
        n_cmp++; if (word_count !== 16'd2) begin n_bad++; $display("FAIL load_word_count: got %0d want 2", word_count); end
        send_byte(8'h7F);
        send_byte(8'hFF);
        n_cmp++; if ({rom_we, rom_addr, rom_data} !== {1'b1, 15'd0, 16'h7FFF}) begin n_bad++; $display("FAIL load_word0: got %h want %h", {rom_we, rom_addr, rom_data}, {1'b1, 15'd0, 16'h7FFF}); end
        send_byte(8'hEC);
        n_cmp++; if (rom_we !== 1'b0) begin n_bad++; $display("FAIL load_we_pulse: got %b want 0", rom_we); end
        send_byte(8'h10);
        idle();
        n_cmp++; if ({rom_we, rom_addr, rom_data} !== {1'b1, 15'd1, 16'hEC10}) begin n_bad++; $display("FAIL load_word1: got %h want %h", {rom_we, rom_addr, rom_data}, {1'b1, 15'd1, 16'hEC10}); end
        n_cmp++; if ({cpu_reset, cpu_clk_en, rx_ready} !== 3'b100) begin n_bad++; $display("FAIL load_rst_enter: got %b want 100", {cpu_reset, cpu_clk_en, rx_ready}); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if ({cpu_reset, cpu_clk_en, rom_we} !== 3'b100) begin n_bad++; $display("FAIL load_rst_hold%0d: got %b want 100", k, {cpu_reset, cpu_clk_en, rom_we}); end
        end
        tick();
        n_cmp++; if ({cpu_reset, cpu_clk_en, rx_ready} !== 3'b010) begin n_bad++; $display("FAIL load_run_enter: got %b want 010", {cpu_reset, cpu_clk_en, rx_ready}); end
        n_cmp++; if (wr_addr_log.size() - base !== 2) begin n_bad++; $display("FAIL load_write_count: got %0d want 2", wr_addr_log.size() - base); end
    endtask

    task automatic test_no_halt();
        for (int i = 0; i < 12; i++) begin
            pc = (i % 2 == 0) ? 16'd2 : 16'd3;
            tick();
            n_cmp++; if ({halted, cpu_clk_en} !== 2'b01) begin n_bad++; $display("FAIL no_halt_%0d: got %b want 01", i, {halted, cpu_clk_en}); end
        end
    endtask

    task automatic test_reset_run();
        reset = 1'b1;
        tick();
        n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL reset_in_run: got %h want %h", out_vec(), RESET_VEC); end
        reset = 1'b0;
        pc = 16'hFFFF;
        tick();
    endtask

    task automatic test_bad_len();
        int base;
        base = wr_addr_log.size();
        send_byte(8'h00);
        send_byte(8'h00);
        n_cmp++; if ({error, rx_ready, cpu_reset, cpu_clk_en} !== 4'b1110) begin n_bad++; $display("FAIL len_zero: got %b want 1110", {error, rx_ready, cpu_reset, cpu_clk_en}); end
        send_byte(8'h80);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL len_clear_a: got %b want 0", error); end
        send_byte(8'h01);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL len_8001: got %b want 1", error); end
        send_byte(8'h00);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL len_clear_b: got %b want 0", error); end
        send_byte(8'h00);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL len_zero_again: got %b want 1", error); end
        send_byte(8'h80);
        send_byte(8'h00);
        idle();
        n_cmp++; if ({error, word_count} !== {1'b0, 16'h8000}) begin n_bad++; $display("FAIL len_max_ok: got %h want %h", {error, word_count}, {1'b0, 16'h8000}); end
        n_cmp++; if (wr_addr_log.size() - base !== 0) begin n_bad++; $display("FAIL len_no_write: got %0d want 0", wr_addr_log.size() - base); end
        apply_reset();
    endtask

    task automatic test_timeout();
        int base;
        int err_cycle;
        int ready_drops;
        base = wr_addr_log.size();
        err_cycle = -1;
        ready_drops = 0;
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h12);
        idle();
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (error === 1'b1 && err_cycle < 0) err_cycle = k;
            if (rx_ready !== 1'b1) ready_drops++;
        end
        n_cmp++; if (err_cycle !== 50) begin n_bad++; $display("FAIL timeout_cycle: got %0d want 50", err_cycle); end
        n_cmp++; if (ready_drops !== 0) begin n_bad++; $display("FAIL timeout_ready: got %0d drops want 0", ready_drops); end
        n_cmp++; if ({cpu_reset, word_count} !== {1'b1, 16'd3}) begin n_bad++; $display("FAIL timeout_state: got %h want %h", {cpu_reset, word_count}, {1'b1, 16'd3}); end
        n_cmp++; if (wr_addr_log.size() - base !== 0) begin n_bad++; $display("FAIL timeout_no_write: got %0d want 0", wr_addr_log.size() - base); end
    endtask

    task automatic test_timeout_accept_wins();
        int err_seen;
        int err_cycle;
        err_seen = 0;
        err_cycle = -1;
        send_byte(8'h00);
        send_byte(8'h02);
        idle();
        for (int k = 1; k <= 49; k++) begin
            tick();
            if (error !== 1'b0) err_seen++;
        end
        send_byte(8'h12);
        idle();
        if (error !== 1'b0) err_seen++;
        n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL accept_wins: got %0d error cycles want 0", err_seen); end
        for (int k = 1; k <= 55; k++) begin
            tick();
            if (error === 1'b1 && err_cycle < 0) err_cycle = k;
        end
        n_cmp++; if (err_cycle !== 50) begin n_bad++; $display("FAIL accept_wins_restart: got %0d want 50", err_cycle); end
        apply_reset();
    endtask

    task automatic test_halt();
        logic [15:0] seq [0:5];
        seq = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
        pc = 16'hFFFF;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        idle();
        n_cmp++; if ({rom_we, rom_addr, rom_data} !== {1'b1, 15'd0, 16'hABCD}) begin n_bad++; $display("FAIL halt_load: got %h want %h", {rom_we, rom_addr, rom_data}, {1'b1, 15'd0, 16'hABCD}); end
        for (int k = 0; k < 4; k++) tick();
        n_cmp++; if (cpu_clk_en !== 1'b1) begin n_bad++; $display("FAIL halt_run: got %b want 1", cpu_clk_en); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early_%0d: got %b want 0", i, halted); end
            pc = seq[i];
            tick();
        end
        n_cmp++; if ({halted, cpu_clk_en, cpu_reset, rx_ready, error} !== 5'b10010) begin n_bad++; $display("FAIL halt_state: got %b want 10010", {halted, cpu_clk_en, cpu_reset, rx_ready, error}); end
    endtask

    task automatic test_reload_from_halted();
        int base;
        base = wr_addr_log.size();
        pc = 16'hFFFF;
        send_byte(8'h00);
        n_cmp++; if ({halted, cpu_reset, cpu_clk_en, rx_ready} !== 4'b0101) begin n_bad++; $display("FAIL reload_first: got %b want 0101", {halted, cpu_reset, cpu_clk_en, rx_ready}); end
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h05);
        idle();
        n_cmp++; if ({rom_we, rom_addr, rom_data, word_count} !== {1'b1, 15'd0, 16'h0005, 16'd1}) begin n_bad++; $display("FAIL reload_write: got %h want %h", {rom_we, rom_addr, rom_data, word_count}, {1'b1, 15'd0, 16'h0005, 16'd1}); end
        for (int k = 1; k <= 3; k++) tick();
        n_cmp++; if ({cpu_reset, cpu_clk_en} !== 2'b10) begin n_bad++; $display("FAIL reload_rst: got %b want 10", {cpu_reset, cpu_clk_en}); end
        tick();
        n_cmp++; if ({cpu_reset, cpu_clk_en, halted} !== 3'b010) begin n_bad++; $display("FAIL reload_run: got %b want 010", {cpu_reset, cpu_clk_en, halted}); end
        n_cmp++; if (wr_addr_log.size() - base !== 1) begin n_bad++; $display("FAIL reload_write_count: got %0d want 1", wr_addr_log.size() - base); end
    endtask

    task automatic test_reset_midload();
        int base;
        apply_reset();
        base = wr_addr_log.size();
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h88;
        tick();
        n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL reset_midload: got %h want %h", out_vec(), RESET_VEC); end
        reset = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) tick();
        n_cmp++; if (wr_addr_log.size() - base !== 3) begin n_bad++; $display("FAIL midload_write_count: got %0d want 3", wr_addr_log.size() - base); end
        if (wr_addr_log.size() - base >= 3) begin
            n_cmp++; if ({wr_addr_log[base], wr_data_log[base]} !== {15'd0, 16'h1122}) begin n_bad++; $display("FAIL midload_word0: got %h want %h", {wr_addr_log[base], wr_data_log[base]}, {15'd0, 16'h1122}); end
            n_cmp++; if ({wr_addr_log[base+2], wr_data_log[base+2]} !== {15'd2, 16'h5566}) begin n_bad++; $display("FAIL midload_word2: got %h want %h", {wr_addr_log[base+2], wr_data_log[base+2]}, {15'd2, 16'h5566}); end
        end
        n_cmp++; if (out_vec() !== RESET_VEC) begin n_bad++; $display("FAIL midload_idle: got %h want %h", out_vec(), RESET_VEC); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 16'hFFFF;
        test_reset();
        test_load_basic();
        test_no_halt();
        test_reset_run();
        test_bad_len();
        test_timeout();
        test_timeout_accept_wins();
        test_halt();
        test_reload_from_halted();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_boot_sequencer.md
Name: cpu_boot_sequencer

Overview:
- Sequences the Hack CPU through load, reset and run phases.
- Receives a program as a byte stream over a valid/ready interface and writes it word-by-word into instruction ROM, holding the CPU in reset during the load.
- Releases the CPU after a fixed reset stretch, then monitors pc to detect the end-of-program self-loop and freezes the CPU.
- Sits between the host/UART receiver, the instruction ROM write port and the CPU's reset/clock-enable.

Parameters:
- ADDR_W, 15, width of ROM address and word counter.
- MAX_WORDS, 32768, largest accepted program length in words.
- RST_CYCLES, 4, cycles cpu_reset is held high after load completes.
- HALT_COUNT, 3, consecutive enabled cycles with unchanged pc that declare a halt.
- TIMEOUT, 1000000, idle cycles mid-transfer before an error is declared.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- rx_valid, input, 1, rx_data holds a byte.
- rx_data, input, 8, program stream byte.
- rx_ready, output, 1, sequencer accepts a byte this cycle.
- rom_we, output, 1, ROM write strobe.
- rom_addr, output, ADDR_W, ROM write address.
- rom_data, output, 16, ROM write word.
- cpu_reset, output, 1, drives the CPU reset input.
- cpu_clk_en, output, 1, CPU advance enable.
- pc, input, 16, CPU program counter.
- halted, output, 1, CPU frozen at end-of-program.
- error, output, 1, load aborted.
- word_count, output, 16, length N of the last accepted program.

Behaviour:
- Interface: clock port is clk; reset port is reset; reset is synchronous and active-high.
- Reset state and outputs: state IDLE; rx_ready=1; rom_we=0; rom_addr=0; rom_data=0; cpu_reset=1; cpu_clk_en=0; halted=0; error=0; word_count=0. All outputs are registered.
- Transfer rule: a byte transfers when rx_valid && rx_ready are both high at a rising edge.
- Stream format: big-endian 16-bit length N, then N words, each sent high byte then low byte.
- States: IDLE, LEN_LO, DATA_HI, DATA_LO, RST, RUN, HALTED, ERROR.
- IDLE: accepted byte becomes len[15:8] -> LEN_LO.
- LEN_LO: accepted byte completes len.
  - If N==0 or N>MAX_WORDS -> ERROR.
  - Otherwise word_count<=N, word index<=0 -> DATA_HI.
- DATA_HI: latch high byte -> DATA_LO.
- DATA_LO: on accept, the next cycle has rom_we=1, rom_addr=index, rom_data={hi,lo}.
  - rom_we is a single-cycle pulse.
  - Index increments. After word N-1 -> RST, else -> DATA_HI.
- Back-to-back bytes are accepted every cycle: no bubbles.
- Timeout: in LEN_LO, DATA_HI and DATA_LO, a cycle counter clears on every accept. Reaching TIMEOUT -> ERROR.
- RST: rx_ready=0, cpu_reset=1, cpu_clk_en=0 for exactly RST_CYCLES cycles -> RUN.
- RUN: cpu_reset=0, cpu_clk_en=1, rx_ready=0.
  - Each cycle compare pc with the registered previous pc.
  - Equal -> increment stable counter; differ -> clear it.
  - Counter reaching HALT_COUNT -> HALTED. cpu_clk_en drops the same edge.
- HALTED: halted=1, cpu_clk_en=0, cpu_reset=0 (CPU state is preserved for inspection), rx_ready=1.
  - Accepted byte = new len hi: halted<=0, cpu_reset<=1 -> LEN_LO.
- ERROR: error=1, cpu_reset=1, cpu_clk_en=0, rx_ready=1.
  - Accepted byte clears error and acts as len hi -> LEN_LO.
- cpu_reset is 1 in every state except RUN and HALTED.
- The ROM is never written in RUN or HALTED.
- The word index is ADDR_W bits wide; N≤MAX_WORDS guarantees no wrap.
- reset asserted in any state, including mid-transfer and RUN, returns to the reset values on the next edge. A partial load is abandoned; ROM contents are left untouched.
- Simultaneous TIMEOUT expiry and accept in the same cycle: the accept wins and the counter clears.

Test Plan:
- Stream 00 02 7F FF EC 10 back-to-back -> writes ROM[0]=16'h7FFF, ROM[1]=16'hEC10; word_count=2; cpu_reset high for 4 cycles after the last write, then cpu_clk_en=1.
- Length bytes 00 00, and separately 80 01 with MAX_WORDS=32768 -> error=1, rom_we never pulses; next byte 00 clears error.
- Load 1 word, then drive pc 0,1,2,2,2,2 in RUN -> halted=1 and cpu_clk_en=0 on the edge after the third repeated comparison; pc 2,3 alternating never halts.
- Send 00 03 12 then stall with TIMEOUT=50 -> ERROR exactly 50 cycles after the last accept; rx_ready stays 1.
- From HALTED, send 00 01 00 05 -> halted falls and cpu_reset rises on the first accept; ROM[0]=16'h0005; normal RST->RUN follows.
- Assert reset during DATA_LO (after 3 of 5 words) and during RUN -> all outputs return to reset values next cycle; no further rom_we.
